// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular sharing of one UART TX byte path; every frame gets a {HDR_TAG, id} header.
// Optional payload stall timeout is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int         NUM_REQ        = 4,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [3:0] HDR_TAG        = 4'hA
) (
    input  logic                 clk_100mhz,
    input  logic                 sys_rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [3:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_pulse,
    output logic [1:0]           fsm_state
);
    // Handshakes: a byte moves on a rising edge where valid && ready; once tx_valid is
    // raised it stays up with tx_data frozen until tx_ready, except across reset.
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    logic [1:0]    state;
    logic          picked;
    logic [3:0]    grant;
    logic [3:0]    last_grant;
    logic [CW-1:0] byte_cnt;
    logic [4:0]    scan_idx;
    logic [3:0]    pick_id;
    logic          pick_found;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          hs;
    logic          payload_end;
    logic          stall_expire;

    // Scan starts one past the previous winner so simultaneous requesters rotate.
    always_comb begin
        scan_idx   = 5'd0;
        pick_id    = 4'd0;
        pick_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = {1'b0, last_grant} + 5'(i);
            if (scan_idx >= 5'(NUM_REQ)) scan_idx = scan_idx - 5'(NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_found && req_valid[j] && (scan_idx == 5'(j))) begin
                    pick_found = 1'b1;
                    pick_id    = 4'(j);
                end
            end
        end
    end

    always_comb begin
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_data    = 8'h00;
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant == 4'(j)) begin
                g_valid      = req_valid[j];
                g_last       = req_last[j];
                g_data       = req_data[8*j +: 8];
                req_ready[j] = (state == ST_PAYLOAD) && tx_ready;
            end
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = {HDR_TAG, grant};
            end
            ST_PAYLOAD: begin
                tx_valid = g_valid;
                tx_data  = g_data;
            end
            default: ;
        endcase
    end

    assign hs          = tx_valid && tx_ready;
    assign payload_end = (state == ST_PAYLOAD) && hs &&
                         (g_last || (byte_cnt == CW'(MAX_LEN - 1)));

`ifdef UART_ARB_TIMEOUT_EN
    localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [SW-1:0] stall_cnt;

    // tx_valid is already low when this fires, so aborting loses no byte.
    assign stall_expire = (state == ST_PAYLOAD) && !g_valid &&
                          (stall_cnt == SW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stall_cnt     <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= stall_expire;
            if ((state != ST_PAYLOAD) || g_valid || stall_expire) stall_cnt <= '0;
            else                                                   stall_cnt <= stall_cnt + SW'(1);
        end
    end
`else
    assign stall_expire  = 1'b0;
    // TIMEOUT_CYCLES is a positive count, so this is a constant low strobe.
    assign timeout_pulse = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            picked     <= 1'b0;
            grant      <= 4'd0;
            last_grant <= 4'(NUM_REQ - 1);
            byte_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // First cycle registers the winner, second cycle opens the header.
                    if (picked) begin
                        state  <= ST_HEADER;
                        picked <= 1'b0;
                    end else if (pick_found) begin
                        grant  <= pick_id;
                        picked <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (hs) begin
                        state    <= ST_PAYLOAD;
                        byte_cnt <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (payload_end || stall_expire) begin
                        state      <= ST_IDLE;
                        last_grant <= grant;
                        byte_cnt   <= '0;
                    end else if (hs) begin
                        byte_cnt <= byte_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign grant_id  = grant;
    assign busy      = (state == ST_HEADER) || (state == ST_PAYLOAD);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters, byte-stream scoreboard and a frame vector table.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int MAX_LEN        = 6;
    localparam int TIMEOUT_CYCLES = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready = 1'b0;
    logic [3:0]           grant_id;
    logic                 busy;
    logic                 timeout_pulse;
    logic [1:0]           fsm_state;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .HDR_TAG(4'hA)
    ) dut (
        .clk_100mhz(clk), .sys_rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse), .fsm_state(fsm_state)
    );

    typedef struct {
        string      name;
        int         req;
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        int         mode;
        logic [7:0] hdr;
        logic [3:0] grant;
    } vec_t;

    logic [8:0] src_q[NUM_REQ][$];
    logic [7:0] exp_q[$];
    logic [NUM_REQ-1:0] fire = '0;
    int ready_mode = 0;
    int checks = 0;
    int errors = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    vec_t vecs[5];
    int n;
    int pulses;
    bit seen;

    // Requester sources: pop on the handshake seen at the previous negedge, then present the next byte.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
        endcase
    end

    // Scoreboard: every serializer handshake must match the next expected byte.
    always @(negedge clk) begin
        fire = req_valid & req_ready;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!tx_valid || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL tx_hold: valid=%0b data=%02h required valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_stream: got extra byte %02h, required none", tx_data);
                end else if (tx_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL tx_stream: got %02h required %02h", tx_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic push_src(input int req, input logic [7:0] data, input logic last);
        src_q[req].push_back({last, data});
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            @(negedge clk); #1;
            done = (exp_q.size() == 0) && srcs_empty() && !busy;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: not drained, exp_left=%0d busy=%0b required 0 and 0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        ready_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] d;
        @(posedge clk);
        ready_mode = v.mode;
        for (int k = 0; k < v.len; k++) begin
            d = v.base + 8'(k) * v.step;
            push_src(v.req, d, k == v.len - 1);
            if (k % MAX_LEN == 0) exp_q.push_back(v.hdr);
            exp_q.push_back(d);
        end
        wait_idle(v.name, 300);
        chk({v.name, "_grant"}, grant_id, v.grant);
        ready_mode = 0;
    endtask

    initial begin
        vecs[0] = '{"two_byte_r0",   0, 2, 8'h11, 8'h11, 0, 8'hA0, 4'd0};
        vecs[1] = '{"backpress_r1",  1, 5, 8'h50, 8'h01, 1, 8'hA1, 4'd1};
        vecs[2] = '{"truncate_r2",   2, 8, 8'h80, 8'h01, 0, 8'hA2, 4'd2};
        vecs[3] = '{"one_byte_r3",   3, 1, 8'hF0, 8'h01, 1, 8'hA3, 4'd3};
        vecs[4] = '{"exact_max_r1",  1, 6, 8'h30, 8'h01, 0, 8'hA1, 4'd1};

        // Reset values while held in reset.
        #12;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_timeout", timeout_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_tx_valid", tx_valid, 0);
        chk("idle_state", fsm_state, 0);

        // Header appears two cycles after the first req_valid.
        @(posedge clk);
        push_src(0, 8'h11, 1'b0);
        push_src(0, 8'h22, 1'b1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        @(negedge clk);
        chk("lat_c0_valid", tx_valid, 0);
        @(negedge clk);
        chk("lat_c1_valid", tx_valid, 0);
        chk("lat_c1_busy", busy, 0);
        @(negedge clk);
        chk("lat_c2_valid", tx_valid, 1);
        chk("lat_c2_data", tx_data, 8'hA0);
        chk("lat_c2_busy", busy, 1);
        wait_idle("single_frame", 50);
        chk("single_busy", busy, 0);

        // Round-robin from reset with all four requesting 1-byte frames.
        do_reset();
        @(posedge clk);
        push_src(0, 8'h10, 1'b1); push_src(0, 8'h11, 1'b1);
        push_src(1, 8'h21, 1'b1);
        push_src(2, 8'h32, 1'b1);
        push_src(3, 8'h43, 1'b1);
        exp_q = '{8'hA0, 8'h10, 8'hA1, 8'h21, 8'hA2, 8'h32, 8'hA3, 8'h43, 8'hA0, 8'h11};
        wait_idle("round_robin", 200);
        chk("rr_grant", grant_id, 0);

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Stalled requester: aborts with the timeout build, holds the grant otherwise.
        @(posedge clk);
        push_src(1, 8'h61, 1'b0);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h61);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk); #1;
            seen = (exp_q.size() == 0);
        end
        chk("stall_first_byte", seen, 1);
        push_src(2, 8'h72, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        exp_q.push_back(8'hA2); exp_q.push_back(8'h72);
        n = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk); #1;
            if (timeout_pulse) begin
                seen = 1'b1;
                n = c;
            end
        end
        chk("timeout_delay", n, 17);
        @(negedge clk); #1;
        chk("timeout_width", timeout_pulse, 0);
`else
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (timeout_pulse) pulses++;
        end
        chk("no_timeout", pulses, 0);
        chk("stall_busy", busy, 1);
        chk("stall_grant", grant_id, 1);
        push_src(1, 8'h62, 1'b1);
        exp_q.push_back(8'h62); exp_q.push_back(8'hA2); exp_q.push_back(8'h72);
`endif
        wait_idle("stall_recover", 200);
        chk("stall_next_grant", grant_id, 2);

        // Reset asserted mid-payload clears everything at once.
        @(posedge clk);
        push_src(3, 8'hC0, 1'b0);
        push_src(3, 8'hC1, 1'b0);
        exp_q.push_back(8'hA3); exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk); #1;
            seen = (exp_q.size() == 0);
        end
        chk("mid_frame_sent", seen, 1);
        @(negedge clk);
        chk("mid_frame_state", fsm_state, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        #1;
        chk("async_busy", busy, 0);
        chk("async_tx_valid", tx_valid, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_grant", grant_id, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        push_src(0, 8'h01, 1'b1);
        push_src(1, 8'h02, 1'b1);
        exp_q = '{8'hA0, 8'h01, 8'hA1, 8'h02};
        wait_idle("post_reset_rr", 100);
        chk("post_reset_grant", grant_id, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
